ram_mfc_controller: RTL and testbench
=====================================

// Module: ram_mfc_controller
// PURPOSE
//   Byte-addressed, big-endian 256x8 data/instruction RAM for the data path.
//   Serves MAR-addressed reads and writes with an MFA request / MFC completion handshake.
//   The control unit asserts MFA and stalls in its memory state until MFC rises.
//   Read data goes to the MDR mux, and the IR loads from it on instruction fetch.
//   Access latency is programmable in wait states, so control-unit stall paths get exercised.
// PARAMETERS
//   AW           8   address width; memory depth is 2**AW bytes
//   WAIT_STATES  2   extra BUSY cycles before an access completes (0..15)
// PORTS
//   CLK      in   1    clock; all state updates on rising edge
//   Reset    in   1    synchronous reset, active-high
//   MFA      in   1    memory function activate (request); level, held until MFC seen
//   RW       in   1    1 = write, 0 = read; sampled with MFA in IDLE
//   Size     in   2    00 byte, 01 halfword, 10 word, 11 reserved
//   Address  in   AW   byte address (from MAR)
//   DataIn   in   32   write data; byte in [7:0], halfword in [15:0], word in [31:0]
//   DataOut  out  32   read data, zero-extended; registered
//   MFC      out  1    memory function complete; registered
//   Fault    out  1    valid with MFC: misaligned or reserved-size access, no effect on memory
// BEHAVIOUR
// - Storage: array Mem[0:2**AW-1] of 8 bits.
//   - Not cleared by reset; benches preload it hierarchically (dp.ram.Mem).
// - Endianness: word at A uses Mem[A]=[31:24], Mem[A+1]=[23:16], Mem[A+2]=[15:8], Mem[A+3]=[7:0].
//   - Halfword at A uses Mem[A]=[15:8], Mem[A+1]=[7:0].
// - Alignment: halfword needs A[0]=0; word needs A[1:0]=00. Aligned accesses never wrap.
// - Reset: state=IDLE, MFC=0, Fault=0, DataOut=0, wait counter=0. Any access in flight is aborted.
// - FSM (registered): IDLE -> BUSY -> DONE -> IDLE.
//   - IDLE: MFC=0. If MFA=1, latch RW, Size, Address, DataIn; cnt<=WAIT_STATES; go BUSY.
//   - BUSY: if cnt!=0, cnt<=cnt-1. If cnt==0, perform the access and go DONE.
//     - Read: DataOut<=assembled, zero-extended data.
//     - Write: update only the Size-selected bytes.
//     - Illegal (misaligned or Size=11): no Mem write, DataOut holds, Fault<=1.
//   - DONE: MFC=1, Fault held. If MFA=0, go IDLE and clear MFC and Fault on that edge.
//     If MFA=1, stay in DONE.
// - Latency: MFA sampled high at edge n gives MFC=1 after edge n+1+WAIT_STATES.
//   With WAIT_STATES=0, MFC rises after edge n+1.
// - Full handshake:
//   - A new request needs MFA=0 for at least one edge after MFC, since DONE must return to IDLE.
//   - MFA held high never starts a second access.
//   - MFA dropping during BUSY does not cancel the access. MFC still pulses for one cycle in DONE.
// - Inputs are ignored outside IDLE. Changes to Address/DataIn/RW/Size during BUSY have no effect.
// - DataOut changes only on a legal read completion or reset. Writes leave DataOut unchanged.
// - Reset in BUSY: no Mem update occurs, even with cnt==0 on the same edge (reset wins).
// TESTING
// - Word write A=0x10, DataIn=0xDEADBEEF, W=2, then read:
//   MFC 3 edges after MFA; Mem[0x10..0x13]=DE,AD,BE,EF; DataOut=0xDEADBEEF.
// - Byte read: preload Mem[0x21]=0x5A, Size=00, A=0x21 -> DataOut=0x0000005A.
//   Byte write 0x77 to 0x22 changes only Mem[0x22].
// - Halfword read A=0x12 after test 1 -> DataOut=0x0000BEEF.
//   Halfword at A=0x13 -> Fault=1 with MFC, Mem and DataOut unchanged.
// - Reset pulse during BUSY of a word write to 0x40 (Mem=0):
//   Mem[0x40..0x43] stays 0; MFC=0, DataOut=0 next cycle; FSM in IDLE.
// - MFA held high 10 cycles after MFC -> exactly one access, MFC stays 1.
//   MFA low for 1 cycle then high -> second access accepted.
//   With W=0, MFC rises 1 edge after MFA is sampled.

Source files
------------

// File: rtl/ram_mfc_controller.sv
// Byte-addressed big-endian RAM with an MFA/MFC handshake and programmable wait states.
// Misaligned or reserved-size accesses complete with Fault and leave memory and DataOut untouched.
module ram_mfc_controller #(
  parameter int unsigned AW          = 8,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          MFA,
  input  logic          RW,
  input  logic [1:0]    Size,
  input  logic [AW-1:0] Address,
  input  logic [31:0]   DataIn,
  output logic [31:0]   DataOut,
  output logic          MFC,
  output logic          Fault
);

  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned CW    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  logic [7:0]    Mem [0:DEPTH-1];

  state_t        state;
  logic [CW-1:0] cnt;
  logic          rw_q;
  logic [1:0]    size_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   data_q;

  logic [AW-1:0] addr1_c;
  logic [AW-1:0] addr2_c;
  logic [AW-1:0] addr3_c;
  logic          illegal_c;
  logic [31:0]   rdata_c;

  assign addr1_c = addr_q + AW'(1);
  assign addr2_c = addr_q + AW'(2);
  assign addr3_c = addr_q + AW'(3);

  // Alignment/size legality and big-endian read assembly for the latched request.
  always_comb begin
    illegal_c = 1'b0;
    rdata_c   = 32'h0;
    case (size_q)
      2'b00: rdata_c = {24'h0, Mem[addr_q]};
      2'b01: begin
        illegal_c = addr_q[0];
        rdata_c   = {16'h0, Mem[addr_q], Mem[addr1_c]};
      end
      2'b10: begin
        illegal_c = |addr_q[1:0];
        rdata_c   = {Mem[addr_q], Mem[addr1_c], Mem[addr2_c], Mem[addr3_c]};
      end
      default: illegal_c = 1'b1;
    endcase
  end

  // Handshake FSM; the access is performed on the edge that leaves BUSY with cnt==0.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      MFC     <= 1'b0;
      Fault   <= 1'b0;
      DataOut <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          MFC <= 1'b0;
          if (MFA) begin
            rw_q   <= RW;
            size_q <= Size;
            addr_q <= Address;
            data_q <= DataIn;
            cnt    <= CW'(WAIT_STATES);
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            state <= DONE;
            MFC   <= 1'b1;
            if (illegal_c) begin
              Fault <= 1'b1;
            end else if (rw_q) begin
              case (size_q)
                2'b00: Mem[addr_q] <= data_q[7:0];
                2'b01: begin
                  Mem[addr_q]  <= data_q[15:8];
                  Mem[addr1_c] <= data_q[7:0];
                end
                default: begin
                  Mem[addr_q]  <= data_q[31:24];
                  Mem[addr1_c] <= data_q[23:16];
                  Mem[addr2_c] <= data_q[15:8];
                  Mem[addr3_c] <= data_q[7:0];
                end
              endcase
            end else begin
              DataOut <= rdata_c;
            end
          end
        end
        DONE: begin
          // MFA held high parks here so one request yields exactly one access.
          if (!MFA) begin
            state <= IDLE;
            MFC   <= 1'b0;
            Fault <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_mfc_controller.sv
// Directed and randomized bench for ram_mfc_controller against a byte-array reference model.
// Covers latency, endianness, faults, handshake corner cases and reset during BUSY.
module tb_ram_mfc_controller;

  localparam int unsigned W = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        mfa;
  logic        rw;
  logic [1:0]  size;
  logic [7:0]  address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        mfc;
  logic        fault;

  logic        mfa0;
  logic [31:0] data_out0;
  logic        mfc0;
  logic        fault0;

  int checks = 0;
  int errors = 0;

  logic [7:0]  model_mem [256];
  logic [31:0] model_dout = 32'h0;

  always #5 clk = ~clk;

  ram_mfc_controller #(.AW(8), .WAIT_STATES(W)) dut (
    .CLK(clk), .Reset(reset), .MFA(mfa), .RW(rw), .Size(size), .Address(address),
    .DataIn(data_in), .DataOut(data_out), .MFC(mfc), .Fault(fault)
  );

  ram_mfc_controller #(.AW(8), .WAIT_STATES(0)) dut0 (
    .CLK(clk), .Reset(reset), .MFA(mfa0), .RW(rw), .Size(size), .Address(address),
    .DataIn(data_in), .DataOut(data_out0), .MFC(mfc0), .Fault(fault0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit is_illegal(input logic [1:0] sz, input logic [7:0] a);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
  endfunction

  // Reference behaviour of one completed access on the WAIT_STATES=W instance.
  task automatic model_access(input logic r, input logic [1:0] sz, input logic [7:0] a,
                              input logic [31:0] d, output logic exp_fault);
    int n;
    logic [31:0] v;
    n = nbytes(sz);
    exp_fault = is_illegal(sz, a);
    if (!exp_fault) begin
      if (r) begin
        for (int i = 0; i < n; i++) model_mem[8'(a + i)] = 8'(d >> (8 * (n - 1 - i)));
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(model_mem[8'(a + i)]);
        model_dout = v;
      end
    end
  endtask

  // Full handshake on dut; inputs are scrambled during BUSY, MFA optionally held after MFC.
  task automatic do_access(input logic r, input logic [1:0] sz, input logic [7:0] a,
                           input logic [31:0] d, input int hold, input string tag);
    logic ef;
    int lat;
    lat = -1;
    @(negedge clk);
    rw = r; size = sz; address = a; data_in = d; mfa = 1'b1;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (mfc) lat = i;
      if (i == 0) begin
        rw = 1'($urandom); size = 2'($urandom); address = 8'($urandom); data_in = $urandom;
      end
    end
    model_access(r, sz, a, d, ef);
    check({tag, "_latency"}, 32'(lat), 32'(W + 1));
    check({tag, "_dout"}, data_out, model_dout);
    check({tag, "_fault"}, 32'(fault), 32'(ef));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      rw = 1'b1; size = 2'b00; address = a; data_in = ~d;
      @(posedge clk); #1;
      check({tag, "_hold_mfc"}, 32'(mfc), 32'd1);
    end
    @(negedge clk);
    mfa = 1'b0;
    @(posedge clk); #1;
    check({tag, "_mfc_clr"}, 32'(mfc), 32'd0);
    check({tag, "_fault_clr"}, 32'(fault), 32'd0);
  endtask

  // Single access on the zero-wait-state instance; returns edges after the sampling edge.
  task automatic access0(input logic r, input logic [31:0] d, output int lat);
    lat = -1;
    @(negedge clk);
    rw = r; size = 2'b10; address = 8'h80; data_in = d; mfa0 = 1'b1;
    for (int i = 0; i < 20 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (mfc0) lat = i;
    end
    @(negedge clk);
    mfa0 = 1'b0;
    @(posedge clk);
  endtask

  initial begin
    logic [31:0] d;
    int lat;
    reset = 1'b1; mfa = 1'b0; mfa0 = 1'b0; rw = 1'b0; size = 2'b00; address = 8'h0; data_in = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mfc", 32'(mfc), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_dout", data_out, 32'h0);
    check("rst0_mfc", 32'(mfc0), 32'd0);
    check("rst0_fault", 32'(fault0), 32'd0);
    check("rst0_dout", data_out0, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 64; k++) do_access(1'b1, 2'b10, 8'(k * 4), $urandom, 0, "init");
    do_access(1'b1, 2'b10, 8'h40, 32'h0, 0, "zero40");

    do_access(1'b1, 2'b10, 8'h10, 32'hDEADBEEF, 0, "t1_wr");
    check("t1_mem10", 32'(dut.Mem[8'h10]), 32'hDE);
    check("t1_mem11", 32'(dut.Mem[8'h11]), 32'hAD);
    check("t1_mem12", 32'(dut.Mem[8'h12]), 32'hBE);
    check("t1_mem13", 32'(dut.Mem[8'h13]), 32'hEF);
    do_access(1'b0, 2'b10, 8'h10, 32'h0, 0, "t1_rd");
    check("t1_rd_val", data_out, 32'hDEADBEEF);

    do_access(1'b1, 2'b00, 8'h21, 32'hFFFFFF5A, 0, "t2_pre");
    do_access(1'b0, 2'b00, 8'h21, 32'h0, 0, "t2_rd");
    check("t2_rd_val", data_out, 32'h0000005A);
    do_access(1'b1, 2'b00, 8'h22, 32'h00000077, 0, "t2_wr");
    check("t2_mem20", 32'(dut.Mem[8'h20]), 32'(model_mem[8'h20]));
    check("t2_mem21", 32'(dut.Mem[8'h21]), 32'h5A);
    check("t2_mem22", 32'(dut.Mem[8'h22]), 32'h77);
    check("t2_mem23", 32'(dut.Mem[8'h23]), 32'(model_mem[8'h23]));

    do_access(1'b0, 2'b01, 8'h12, 32'h0, 0, "t3_half");
    check("t3_half_val", data_out, 32'h0000BEEF);
    do_access(1'b0, 2'b01, 8'h13, 32'h0, 0, "t3_mis_rd");
    check("t3_mis_rd_hold", data_out, 32'h0000BEEF);
    do_access(1'b1, 2'b01, 8'h13, 32'h1234, 0, "t3_mis_wr");
    check("t3_mis_mem13", 32'(dut.Mem[8'h13]), 32'hEF);
    check("t3_mis_mem14", 32'(dut.Mem[8'h14]), 32'(model_mem[8'h14]));
    do_access(1'b0, 2'b11, 8'h10, 32'h0, 0, "t3_rsvd");
    do_access(1'b1, 2'b10, 8'h22, 32'h0, 0, "t3_mis_word");

    // Reset lands on the edge that would have performed the write.
    @(negedge clk);
    rw = 1'b1; size = 2'b10; address = 8'h40; data_in = 32'hFFFFFFFF; mfa = 1'b1;
    repeat (W + 1) @(posedge clk);
    @(negedge clk);
    reset = 1'b1; mfa = 1'b0;
    @(posedge clk); #1;
    model_dout = 32'h0;
    check("t4_mfc", 32'(mfc), 32'd0);
    check("t4_dout", data_out, 32'h0);
    check("t4_fault", 32'(fault), 32'd0);
    for (int i = 0; i < 4; i++) check("t4_mem", 32'(dut.Mem[8'(8'h40 + i)]), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    do_access(1'b0, 2'b10, 8'h40, 32'h0, 0, "t4_idle");

    do_access(1'b1, 2'b00, 8'h30, 32'h11, 10, "t5_hold");
    check("t5_single", 32'(dut.Mem[8'h30]), 32'h11);
    do_access(1'b1, 2'b00, 8'h30, 32'h22, 0, "t5_second");
    check("t5_second_mem", 32'(dut.Mem[8'h30]), 32'h22);

    // MFA withdrawn during BUSY still completes with a one-cycle MFC pulse.
    @(negedge clk);
    rw = 1'b0; size = 2'b10; address = 8'h10; mfa = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mfa = 1'b0;
    for (int i = 1; i <= W + 2; i++) begin
      @(posedge clk); #1;
      check("t6_pulse", 32'(mfc), (i == W + 1) ? 32'd1 : 32'd0);
    end
    check("t6_dout", data_out, 32'hDEADBEEF);
    model_dout = 32'hDEADBEEF;

    access0(1'b1, 32'hCAFEF00D, lat);
    check("w0_wr_latency", 32'(lat), 32'd1);
    access0(1'b0, 32'h0, lat);
    check("w0_rd_latency", 32'(lat), 32'd1);
    check("w0_rd_val", data_out0, 32'hCAFEF00D);

    for (int k = 0; k < 150; k++) begin
      d = $urandom;
      do_access(1'($urandom), 2'($urandom), 8'($urandom), d, ($urandom_range(0, 7) == 0) ? 2 : 0, "rand");
    end

    for (int i = 0; i < 256; i++) check("final_mem", 32'(dut.Mem[8'(i)]), 32'(model_mem[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
